// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

  // Parity bit a well-formed frame carries so that data plus parity has an odd number of ones.
  function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] data);
    return ~(^data);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus level debounce for the PS/2 clock line.
// Emits a one-cycle pulse when the filtered level falls.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic fall
);

  localparam int CNT_W = $clog2(FILTER_LEN);

  logic             s1, s2, filtered;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1       <= 1'b1;
      s2       <= 1'b1;
      filtered <= 1'b1;
      cnt      <= '0;
      fall     <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      fall <= 1'b0;
      // Any sample that agrees with the filtered level restarts the run.
      if (s2 != filtered) begin
        if (cnt == CNT_W'(FILTER_LEN - 1)) begin
          filtered <= s2;
          cnt      <= '0;
          fall     <= ~s2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: conditioned inputs, framed/parity-checked
// byte capture with an inactivity watchdog, feeding a fall-through FIFO.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2c,
  input  logic                          ps2d,
  input  logic                          rx_en,
  input  logic                          rd_en,
  input  logic                          clr_ovf,
  output logic [7:0]                    dout,
  output logic                          valid,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          err_parity,
  output logic                          err_frame,
  output logic                          err_timeout,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(PS2_FRAME_BITS);

  logic                     fall;
  logic                     d_s1, d_s2;
  state_t                   state;
  logic [BW-1:0]            bit_cnt;
  logic [PS2_DATA_BITS-1:0] shift;
  logic                     par_bit;
  logic [WW-1:0]            wdog;
  logic                     push, pop, wr, is_full;
  logic [7:0]               mem [FIFO_DEPTH];
  logic [AW-1:0]            wptr, rptr;
  logic [CW-1:0]            cnt;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk   (clk),
    .reset (reset),
    .raw   (ps2c),
    .fall  (fall)
  );

  // Data only needs metastability protection; it is sampled well inside its stable window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_s1 <= 1'b1;
      d_s2 <= 1'b1;
    end else begin
      d_s1 <= ps2d;
      d_s2 <= d_s1;
    end
  end

  assign push = fall && (state == STOP) && d_s2 && (par_bit == odd_parity(shift));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      par_bit     <= 1'b0;
      wdog        <= '0;
      err_parity  <= 1'b0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_parity  <= 1'b0;
      err_frame   <= 1'b0;
      err_timeout <= 1'b0;
      if (state == IDLE) begin
        wdog <= '0;
        if (fall && rx_en && !d_s2) begin
          state   <= DATA;
          bit_cnt <= '0;
        end
      end else if (fall) begin
        wdog <= '0;
        case (state)
          DATA: begin
            shift   <= {d_s2, shift[PS2_DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == BW'(PS2_DATA_BITS - 1)) state <= PARITY;
          end
          PARITY: begin
            par_bit <= d_s2;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!d_s2)                              err_frame  <= 1'b1;
            else if (par_bit != odd_parity(shift)) err_parity <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end else if (wdog == WW'(TIMEOUT_CYCLES - 1)) begin
        state       <= IDLE;
        wdog        <= '0;
        err_timeout <= 1'b1;
      end else begin
        wdog <= wdog + 1'b1;
      end
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign is_full = (cnt == CW'(FIFO_DEPTH));
  assign pop     = rd_en && (cnt != '0);
  assign wr      = push && (!is_full || pop);

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= shift;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      case ({wr, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (push && is_full && !pop) overflow <= 1'b1;
      else if (clr_ovf)            overflow <= 1'b0;
    end
  end

  assign valid = (cnt != '0);
  assign full  = is_full;
  assign count = cnt;
  assign dout  = valid ? mem[rptr] : 8'h00;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: a queue-based frame model checked every cycle,
// plus literal expectations on selected outputs.
module tb_ps2_rx_fifo;

  localparam int FL    = 8;
  localparam int TO    = 400;
  localparam int DEPTH = 8;
  localparam int HALF  = 40;

  logic       clk = 1'b0;
  logic       reset, ps2c, ps2d, rx_en, rd_en, clr_ovf;
  logic [7:0] dout;
  logic       valid, full, err_parity, err_frame, err_timeout, overflow;
  logic [3:0] count;

  logic [7:0] q[$];
  bit         exp_ovf, exp_perr, exp_ferr, exp_terr;
  int         total, bad;

  ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en),
    .rd_en(rd_en), .clr_ovf(clr_ovf), .dout(dout), .valid(valid), .full(full),
    .count(count), .err_parity(err_parity), .err_frame(err_frame),
    .err_timeout(err_timeout), .overflow(overflow)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("valid", valid, int'(q.size() > 0));
      chk("dout", dout, (q.size() > 0) ? int'(q[0]) : 0);
      chk("count", count, q.size());
      chk("full", full, int'(q.size() == DEPTH));
      chk("overflow", overflow, exp_ovf);
      chk("err_parity", err_parity, exp_perr);
      chk("err_frame", err_frame, exp_ferr);
      chk("err_timeout", err_timeout, exp_terr);
    end
  end

  // Frame outcome from the protocol rules: stop bit first, then odd parity, then capacity.
  task automatic stop_outcome(input logic [7:0] data, input logic par, input logic stp);
    if (!stp)                  exp_ferr = 1'b1;
    else if (^{data, par} == 0) exp_perr = 1'b1;
    else if (q.size() < DEPTH) q.push_back(data);
    else                       exp_ovf = 1'b1;
  endtask

  // Sends the first nbits bits of a frame. A short frame with stall=1 then waits out the watchdog.
  task automatic send_frame(input logic [7:0] data, input logic par, input logic stp,
                            input int nbits, input bit pop_at_stop, input bit stall);
    logic [10:0] bits;
    bit          started;
    bits    = {stp, par, data, 1'b0};
    started = rx_en;
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1 ps2d = bits[i];
      repeat (HALF - 1) @(posedge clk);
      #1 ps2c = 1'b0;
      if (i == 10) begin
        repeat (FL + 2) @(posedge clk);
        if (pop_at_stop) #1 rd_en = 1'b1;
        @(posedge clk);
        if (started) begin
          if (pop_at_stop && q.size() > 0) void'(q.pop_front());
          stop_outcome(data, par, stp);
        end
        #1 rd_en = 1'b0;
        @(posedge clk);
        exp_perr = 1'b0; exp_ferr = 1'b0;
        repeat (HALF - FL - 4) @(posedge clk);
      end else if (stall && i == nbits - 1) begin
        repeat (FL + 3) @(posedge clk);
        repeat (HALF - FL - 3) @(posedge clk);
        #1 ps2c = 1'b1;
        repeat (TO - HALF + FL + 3) @(posedge clk);
        exp_terr = 1'b1;
        @(posedge clk);
        exp_terr = 1'b0;
      end else begin
        repeat (HALF) @(posedge clk);
      end
      #1 ps2c = 1'b1;
    end
    repeat (HALF) @(posedge clk);
  endtask

  task automatic good_frame(input logic [7:0] data, input bit pop_at_stop);
    send_frame(data, ~(^data), 1'b1, 11, pop_at_stop, 1'b0);
  endtask

  task automatic pop_one();
    @(posedge clk); #1 rd_en = 1'b1;
    @(posedge clk);
    if (q.size() > 0) void'(q.pop_front());
    #1 rd_en = 1'b0;
  endtask

  task automatic clear_ovf();
    @(posedge clk); #1 clr_ovf = 1'b1;
    @(posedge clk);
    exp_ovf = 1'b0;
    #1 clr_ovf = 1'b0;
  endtask

  initial begin
    #50_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    reset = 1'b1; ps2c = 1'b1; ps2d = 1'b1; rx_en = 1'b1; rd_en = 1'b0; clr_ovf = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", valid, 0);
    chk("reset_count", count, 0);
    #1 reset = 1'b0;

    // Basic good frame
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    @(negedge clk);
    chk("t1_dout", dout, 8'h1C);
    chk("t1_count", count, 1);
    pop_one();
    @(negedge clk);
    chk("t1_valid_after_pop", valid, 0);

    // Parity error then the corrected frame
    send_frame(8'hF0, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_count", count, 0);
    send_frame(8'hF0, 1'b1, 1'b1, 11, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_dout", dout, 8'hF0);
    pop_one();

    // Stop-bit errors, alone and combined with bad parity
    send_frame(8'h55, 1'b1, 1'b0, 11, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0, 11, 1'b0, 1'b0);
    @(negedge clk);
    chk("t3_count", count, 0);

    // Watchdog abort after start plus four data bits
    send_frame(8'h0F, 1'b1, 1'b1, 5, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b1, 1'b1, 11, 1'b0, 1'b0);
    @(negedge clk);
    chk("t4_dout", dout, 8'h5A);
    pop_one();

    // Receiver disabled: whole frame ignored
    rx_en = 1'b0;
    good_frame(8'h11, 1'b0);
    rx_en = 1'b1;
    @(negedge clk);
    chk("rxen_count", count, 0);

    // Fill, overflow, drain in order
    for (int i = 1; i <= 8; i++) good_frame(8'(i), 1'b0);
    @(negedge clk);
    chk("t5_full", full, 1);
    chk("t5_count8", count, 8);
    good_frame(8'h09, 1'b0);
    @(negedge clk);
    chk("t5_ovf_set", overflow, 1);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("t5_pop_order", dout, i);
      pop_one();
    end
    clear_ovf();
    @(negedge clk);
    chk("t5_ovf_clr", overflow, 0);
    for (int i = 1; i <= 8; i++) good_frame(8'(i), 1'b0);
    good_frame(8'h09, 1'b1);
    @(negedge clk);
    chk("t5_pushpop_count", count, 8);
    chk("t5_pushpop_ovf", overflow, 0);
    chk("t5_pushpop_head", dout, 8'h02);
    repeat (8) pop_one();

    // Short low glitch with data low must not start a frame
    @(posedge clk); #1 ps2d = 1'b0; ps2c = 1'b0;
    repeat (3) @(posedge clk);
    #1 ps2c = 1'b1; ps2d = 1'b1;
    repeat (30) @(posedge clk);
    good_frame(8'h3C, 1'b0);
    @(negedge clk);
    chk("t6_glitch_dout", dout, 8'h3C);

    // Reset in the middle of a frame, with a byte already queued
    send_frame(8'hC3, 1'b1, 1'b1, 4, 1'b0, 1'b0);
    @(posedge clk); #1 reset = 1'b1;
    q.delete(); exp_ovf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t6_reset_valid", valid, 0);
    chk("t6_reset_count", count, 0);
    #1 reset = 1'b0;
    good_frame(8'hA7, 1'b0);
    @(negedge clk);
    chk("t6_after_reset_dout", dout, 8'hA7);
    pop_one();
    repeat (5) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Next-generation PS/2 device-to-host receiver. It adds the following over the current receiver:
- input synchronisation and glitch filtering of the PS/2 lines
- start, odd-parity and stop-bit checking
- an inactivity watchdog
- a parametrised first-word-fall-through output FIFO

It sits between the PS/2 connector pins and the keyboard/mouse decode logic, which pops bytes at its own pace.

Parameters:
FILTER_LEN, 8, consecutive clk samples a synchronised ps2c level must hold before the filtered clock changes (≥2).
TIMEOUT_CYCLES, 10000, clk cycles without a filtered ps2c falling edge before an in-progress frame is aborted (200 µs at 50 MHz).
FIFO_DEPTH, 8, output FIFO entries (power of two, ≥2).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
ps2c  input  1  raw PS/2 clock pin (asynchronous)
ps2d  input  1  raw PS/2 data pin (asynchronous)
rx_en  input  1  permits the start of a new frame
rd_en  input  1  pop the FIFO head
clr_ovf  input  1  clears the overflow flag
dout  output  8  FIFO head byte (valid when valid=1)
valid  output  1  FIFO not empty
full  output  1  FIFO full
count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy
err_parity  output  1  one-cycle pulse: parity mismatch
err_frame  output  1  one-cycle pulse: stop bit was 0
err_timeout  output  1  one-cycle pulse: watchdog abort
overflow  output  1  sticky: a good byte was dropped because the FIFO was full

Behaviour:
- Reset (asynchronous, active-high, clock clk):
  - all outputs 0, FIFO empty, state IDLE
  - synchroniser and filter registers set to 1 (idle line level)
  - reset mid-frame discards the partial frame
- Input conditioning:
  - ps2c and ps2d each pass through a 2-flop synchroniser.
  - Filtered ps2c takes the synchronised value after FILTER_LEN consecutive equal samples. Shorter pulses are ignored.
  - fall = filtered ps2c 1→0, one cycle wide. ps2d (synchronised) is sampled on the fall cycle.
- FSM states (transitions occur only on fall unless noted):
  - IDLE: on fall with rx_en=1 and data=0 → DATA (bit count=0). With data=1 (bad start) stay IDLE, no error. With rx_en=0, ignore.
  - DATA: shift data in LSB-first. After the 8th bit → PARITY.
  - PARITY: capture bit; → STOP.
  - STOP: evaluate the frame; → IDLE.
- Frame checks at STOP, in order of precedence:
  - stop bit = 0 → err_frame pulse, no push
  - else XOR(data, parity) = 0 → err_parity pulse, no push
  - else push the byte
  - Error pulses occur on the cycle after the stop-bit fall.
- rx_en deassertion mid-frame does not abort the frame.
- Watchdog:
  - Counter cleared on every fall and while in IDLE; counts otherwise.
  - Reaching TIMEOUT_CYCLES in a non-IDLE state: → IDLE, err_timeout pulses one cycle, partial data discarded.
- FIFO (first-word fall-through):
  - A pushed byte appears on dout with valid=1 one cycle after the stop-bit fall, i.e. the same cycle as the error pulses would.
  - dout holds the head. rd_en while empty is ignored.
  - Push when full with no simultaneous pop: byte dropped, overflow set.
  - Push and pop in the same cycle when full: both take effect, count unchanged, no overflow.
  - Push and pop in the same cycle when empty: push only.
  - Pointers wrap modulo FIFO_DEPTH.
  - overflow clears on clr_ovf. A set in the same cycle as clr_ovf wins.
- Only one of err_parity, err_frame, err_timeout can pulse in any cycle.

Decomposition:
- Package ps2_pkg holds:
  - state enum: IDLE, DATA, PARITY, STOP
  - constants: PS2_DATA_BITS=8, PS2_FRAME_BITS=11
  - the odd-parity helper function
- One sub-module, ps2_line_filter: 2-flop synchroniser, FILTER_LEN debounce and falling-edge pulse. Instantiated for ps2c; ps2d uses the synchroniser only.
- The FIFO stays inline.

Test Plan:
1. Frame 0x1C, parity 0, stop 1 at a 12 kHz PS/2 clock → valid=1, dout=0x1C, count=1, no error pulses; rd_en → valid=0.
2. Frame 0xF0 with parity 0 (wrong; correct is 1) → single err_parity pulse, count stays 0. Then 0xF0 with parity 1 → dout=0xF0.
3. Frame 0x55 with stop bit 0 → err_frame pulse, no push. Stop=0 and bad parity together → err_frame only.
4. Stop ps2c after 4 data bits for TIMEOUT_CYCLES → err_timeout exactly once, state IDLE. Next frame 0x5A → dout=0x5A, no error.
5. Push 8 bytes 0x01..0x08 → full=1, count=8. 9th byte 0x09 → overflow=1, byte dropped. Pop 8 → 0x01..0x08 in order. clr_ovf → overflow=0. Repeat with a pop in the 9th push cycle → no overflow.
6. 3-cycle low glitch on ps2c in IDLE (FILTER_LEN=8) → no state change, no errors. Assert reset mid-frame → all outputs 0, FIFO empty; the next full frame is received correctly.
